// File: rtl/pq_pkg.sv
// Shared priority-queue types and helpers: fixed kv_t for pq_if users plus
// width-generic key compare and sentinel functions used by pq_sortq.
package pq_pkg;

  localparam int KEY_WIDTH   = 16;
  localparam int VAL_WIDTH   = 16;
  localparam int PQ_CAPACITY = 16;
  localparam int MAX_KW      = 64;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_ENQ,
    OP_DEQ,
    OP_REPL
  } op_t;

  // Strict priority compare: a beats b. Callers zero-extend to MAX_KW.
  function automatic logic key_better(input logic [MAX_KW-1:0] a,
                                      input logic [MAX_KW-1:0] b,
                                      input logic min_first);
    return min_first ? (a < b) : (a > b);
  endfunction

  function automatic logic [MAX_KW-1:0] sentinel_key(input int kw, input logic min_first);
    logic [MAX_KW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_KW; i++) begin
      if (min_first && i < kw) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pq_sortq_cell.sv
// One storage cell of the sorted shift-register queue: compares kvi against its
// own key and picks hold / kvi / upper / lower neighbour for the next state.
import pq_pkg::*;

module pq_sortq_cell #(
  parameter int KW        = 16,
  parameter int VW        = 16,
  parameter bit MIN_FIRST = 1'b1,
  parameter bit FIRST     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  op_t              op,
  input  logic [KW+VW-1:0] kvi,
  input  logic             up_vld,
  input  logic [KW+VW-1:0] up_kv,
  input  logic             up_ge,
  input  logic             lo_vld,
  input  logic [KW+VW-1:0] lo_kv,
  input  logic             lo_ge,
  output logic             vld,
  output logic [KW+VW-1:0] kv,
  output logic             ge
);

  localparam int KVW = KW + VW;

  logic [KW-1:0] own_key;
  logic [KW-1:0] kvi_key;

  assign own_key = kv[KVW-1 -: KW];
  assign kvi_key = kvi[KVW-1 -: KW];

  // Own entry is better-or-equal than kvi, so kvi must land behind it (FIFO ties).
  assign ge = vld && !key_better(MAX_KW'(kvi_key), MAX_KW'(own_key), MIN_FIRST);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      kv  <= '0;
    end else begin
      unique case (op)
        OP_ENQ: begin
          if (!ge) begin
            if (up_ge) begin
              vld <= 1'b1;
              kv  <= kvi;
            end else begin
              vld <= up_vld;
              kv  <= up_kv;
            end
          end
        end
        OP_DEQ: begin
          vld <= lo_vld;
          kv  <= lo_kv;
        end
        // Replace drops the head, so the head's own compare result is irrelevant.
        OP_REPL: begin
          if (lo_ge) begin
            vld <= lo_vld;
            kv  <= lo_kv;
          end else if (FIRST || ge) begin
            vld <= 1'b1;
            kv  <= kvi;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/pq_sortq.sv
// Shift-register priority queue with single-cycle enq/deq/replace, min/max order
// and optional evict-on-full; never stalls, overflow/underflow reported as pulses.
import pq_pkg::*;

module pq_sortq #(
  parameter int KW        = 16,
  parameter int VW        = 16,
  parameter int DEPTH     = 16,
  parameter bit MIN_FIRST = 1'b1,
  parameter bit EVICT     = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq,
  input  logic                       deq,
  input  logic [KW+VW-1:0]           kvi,
  output logic [KW+VW-1:0]           kvo,
  output logic                       full,
  output logic                       empty,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  output logic [KW+VW-1:0]           ev_kv,
  output logic                       unf
);

  localparam int KVW = KW + VW;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam logic [MAX_KW-1:0] SENT_WIDE = sentinel_key(KW, MIN_FIRST);
  localparam logic [KW-1:0]     SENT_KEY  = SENT_WIDE[KW-1:0];
  localparam logic [KVW-1:0]    SENT_KV   = KVW'(SENT_KEY) << VW;

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] ge;
  logic [KVW-1:0]   kv [DEPTH];

  logic [CW-1:0]  count_q;
  logic           is_full;
  logic           is_empty;
  logic           evict_ok;
  op_t            op;
  logic           ovf_n;
  logic           unf_n;
  logic [KVW-1:0] ev_n;

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);
  assign evict_ok = EVICT && key_better(MAX_KW'(kvi[KVW-1 -: KW]),
                                        MAX_KW'(kv[DEPTH-1][KVW-1 -: KW]), MIN_FIRST);

  always_comb begin
    op    = OP_HOLD;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    ev_n  = '0;
    if (enq && deq) begin
      if (is_empty) begin
        op    = OP_ENQ;
        unf_n = 1'b1;
      end else begin
        op = OP_REPL;
      end
    end else if (enq) begin
      if (!is_full) begin
        op = OP_ENQ;
      end else begin
        ovf_n = 1'b1;
        // A plain enq on a full queue shifts the tail out, which is the eviction.
        if (evict_ok) begin
          op   = OP_ENQ;
          ev_n = kv[DEPTH-1];
        end else begin
          ev_n = kvi;
        end
      end
    end else if (deq) begin
      if (is_empty) unf_n = 1'b1;
      else          op    = OP_DEQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      ev_kv   <= '0;
    end else begin
      ovf   <= ovf_n;
      unf   <= unf_n;
      ev_kv <= ev_n;
      if (op == OP_ENQ && !is_full) count_q <= count_q + CW'(1);
      else if (op == OP_DEQ)        count_q <= count_q - CW'(1);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic           up_vld;
    logic [KVW-1:0] up_kv;
    logic           up_ge;
    logic           lo_vld;
    logic [KVW-1:0] lo_kv;
    logic           lo_ge;

    if (i == 0) begin : g_top
      assign up_vld = 1'b0;
      assign up_kv  = '0;
      assign up_ge  = 1'b1;
    end else begin : g_mid_up
      assign up_vld = vld[i-1];
      assign up_kv  = kv[i-1];
      assign up_ge  = ge[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign lo_vld = 1'b0;
      assign lo_kv  = '0;
      assign lo_ge  = 1'b0;
    end else begin : g_mid_lo
      assign lo_vld = vld[i+1];
      assign lo_kv  = kv[i+1];
      assign lo_ge  = ge[i+1];
    end

    pq_sortq_cell #(
      .KW(KW), .VW(VW), .MIN_FIRST(MIN_FIRST), .FIRST(i == 0)
    ) u_cell (
      .clk(clk), .rst(rst), .op(op), .kvi(kvi),
      .up_vld(up_vld), .up_kv(up_kv), .up_ge(up_ge),
      .lo_vld(lo_vld), .lo_kv(lo_kv), .lo_ge(lo_ge),
      .vld(vld[i]), .kv(kv[i]), .ge(ge[i])
    );
  end

  assign kvo   = vld[0] ? kv[0] : SENT_KV;
  assign count = count_q;
  assign full  = is_full;
  assign empty = is_empty;
  assign busy  = 1'b0;

endmodule

// File: tb/tb_pq_sortq.sv
// Bench: three pq_sortq instances (min/drop, min/evict, max/drop) driven in lockstep
// and checked by directed scenarios plus a random run against an array-based model.
module tb_pq_sortq;

  logic        clk = 1'b0;
  logic        rst, enq, deq;
  logic [15:0] kvi;

  logic [15:0] kvo [3];
  logic [15:0] ev_kv [3];
  logic [2:0]  count [3];
  logic        full [3], empty [3], busy [3], ovf [3], unf [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: sorted entry lists per configuration.
  logic [15:0] m [3][4];
  int          mc [3];
  logic        e_ovf [3], e_unf [3];
  logic [15:0] e_ev [3];

  always #5 clk = ~clk;

  pq_sortq #(.KW(8), .VW(8), .DEPTH(4), .MIN_FIRST(1'b1), .EVICT(1'b0)) dut_drop (
    .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi(kvi), .kvo(kvo[0]),
    .full(full[0]), .empty(empty[0]), .busy(busy[0]), .count(count[0]),
    .ovf(ovf[0]), .ev_kv(ev_kv[0]), .unf(unf[0]));

  pq_sortq #(.KW(8), .VW(8), .DEPTH(4), .MIN_FIRST(1'b1), .EVICT(1'b1)) dut_evict (
    .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi(kvi), .kvo(kvo[1]),
    .full(full[1]), .empty(empty[1]), .busy(busy[1]), .count(count[1]),
    .ovf(ovf[1]), .ev_kv(ev_kv[1]), .unf(unf[1]));

  pq_sortq #(.KW(8), .VW(8), .DEPTH(4), .MIN_FIRST(1'b0), .EVICT(1'b0)) dut_max (
    .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi(kvi), .kvo(kvo[2]),
    .full(full[2]), .empty(empty[2]), .busy(busy[2]), .count(count[2]),
    .ovf(ovf[2]), .ev_kv(ev_kv[2]), .unf(unf[2]));

  function automatic logic better(input int c, input logic [7:0] a, input logic [7:0] b);
    return (c != 2) ? (a < b) : (a > b);
  endfunction

  function automatic logic [15:0] sentinel(input int c);
    return (c == 2) ? 16'h0000 : 16'hFF00;
  endfunction

  function automatic logic [15:0] exp_kvo(input int c);
    return (mc[c] > 0) ? m[c][0] : sentinel(c);
  endfunction

  // Stable sorted insert: new entry goes before the first strictly-worse entry.
  task automatic model_insert(input int c, input logic [15:0] x);
    int   p;
    logic found;
    logic [7:0] xk, ek;
    p = mc[c];
    found = 1'b0;
    xk = x[15:8];
    for (int j = 0; j < mc[c]; j++) begin
      ek = m[c][j][15:8];
      if (!found && better(c, xk, ek)) begin
        p = j;
        found = 1'b1;
      end
    end
    for (int j = 3; j > 0; j--) if (j > p) m[c][j] = m[c][j-1];
    m[c][p] = x;
    mc[c]++;
  endtask

  task automatic model_pop(input int c);
    for (int j = 0; j < 3; j++) m[c][j] = m[c][j+1];
    mc[c]--;
  endtask

  task automatic model_update();
    logic [7:0] kk, tk;
    for (int c = 0; c < 3; c++) begin
      e_ovf[c] = 1'b0;
      e_unf[c] = 1'b0;
      e_ev[c]  = 16'h0;
      kk = kvi[15:8];
      if (rst) begin
        mc[c] = 0;
      end else if (enq && deq) begin
        if (mc[c] == 0) begin
          model_insert(c, kvi);
          e_unf[c] = 1'b1;
        end else begin
          model_pop(c);
          model_insert(c, kvi);
        end
      end else if (enq) begin
        if (mc[c] < 4) begin
          model_insert(c, kvi);
        end else begin
          e_ovf[c] = 1'b1;
          tk = m[c][3][15:8];
          if (c == 1 && better(c, kk, tk)) begin
            e_ev[c] = m[c][3];
            mc[c] = 3;
            model_insert(c, kvi);
          end else begin
            e_ev[c] = kvi;
          end
        end
      end else if (deq) begin
        if (mc[c] == 0) e_unf[c] = 1'b1;
        else            model_pop(c);
      end
    end
  endtask

  // Drive one cycle from a negedge, let the edge land, return at the next negedge.
  task automatic step(input logic r, input logic e, input logic d, input logic [15:0] k);
    rst = r; enq = e; deq = d; kvi = k;
    @(posedge clk);
    model_update();
    @(negedge clk);
    rst = 1'b0; enq = 1'b0; deq = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0);
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if ({kvo[c], count[c], full[c], empty[c], busy[c], ovf[c], unf[c], ev_kv[c]} !==
          {sentinel(c), 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
        n_fail++;
        $display("FAIL reset dut%0d: kvo=%h count=%0d full=%b empty=%b busy=%b ovf=%b unf=%b ev=%h, want kvo=%h count=0 empty=1 rest 0",
                 c, kvo[c], count[c], full[c], empty[c], busy[c], ovf[c], unf[c], ev_kv[c], sentinel(c));
      end
    end
  endtask

  task automatic test_sorted();
    logic [15:0] want [3];
    want[0] = 16'h0A0B; want[1] = 16'h140C; want[2] = 16'h1E0A;
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h1E0A);
    step(1'b0, 1'b1, 1'b0, 16'h0A0B);
    step(1'b0, 1'b1, 1'b0, 16'h140C);
    n_tests++;
    if (kvo[0] !== 16'h0A0B || count[0] !== 3'd3) begin
      n_fail++;
      $display("FAIL sorted_head: kvo=%h count=%0d, want 0a0b count=3", kvo[0], count[0]);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (kvo[0] !== want[i]) begin
        n_fail++;
        $display("FAIL sorted_deq%0d: kvo=%h want %h", i, kvo[0], want[i]);
      end
      step(1'b0, 1'b0, 1'b1, 16'h0);
    end
    n_tests++;
    if (empty[0] !== 1'b1 || kvo[0] !== 16'hFF00) begin
      n_fail++;
      $display("FAIL sorted_drained: empty=%b kvo=%h, want empty=1 kvo=ff00", empty[0], kvo[0]);
    end
  endtask

  task automatic test_ties();
    step(1'b0, 1'b1, 1'b0, 16'h050A);
    step(1'b0, 1'b1, 1'b0, 16'h050B);
    step(1'b0, 1'b1, 1'b0, 16'h050C);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (kvo[0] !== (16'h050A + 16'(i))) begin
        n_fail++;
        $display("FAIL ties_deq%0d: kvo=%h want %h", i, kvo[0], 16'h050A + 16'(i));
      end
      step(1'b0, 1'b0, 1'b1, 16'h0);
    end
  endtask

  task automatic fill4();
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0A01);
    step(1'b0, 1'b1, 1'b0, 16'h1402);
    step(1'b0, 1'b1, 1'b0, 16'h1E03);
    step(1'b0, 1'b1, 1'b0, 16'h2804);
  endtask

  task automatic test_overflow();
    fill4();
    step(1'b0, 1'b1, 1'b0, 16'h0158);
    n_tests++;
    if ({ovf[0], ev_kv[0], count[0], kvo[0]} !== {1'b1, 16'h0158, 3'd4, 16'h0A01}) begin
      n_fail++;
      $display("FAIL ovf_drop: ovf=%b ev=%h count=%0d kvo=%h, want 1 0158 4 0a01",
               ovf[0], ev_kv[0], count[0], kvo[0]);
    end
    n_tests++;
    if ({ovf[1], ev_kv[1], count[1], kvo[1]} !== {1'b1, 16'h2804, 3'd4, 16'h0158}) begin
      n_fail++;
      $display("FAIL ovf_evict: ovf=%b ev=%h count=%0d kvo=%h, want 1 2804 4 0158",
               ovf[1], ev_kv[1], count[1], kvo[1]);
    end
    step(1'b0, 1'b0, 1'b0, 16'h0);
    n_tests++;
    if (ovf[0] !== 1'b0 || ovf[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_pulse: ovf0=%b ovf1=%b, want 0 0", ovf[0], ovf[1]);
    end
    step(1'b0, 1'b1, 1'b0, 16'h3259);
    n_tests++;
    if ({ovf[1], ev_kv[1], kvo[1]} !== {1'b1, 16'h3259, 16'h0158}) begin
      n_fail++;
      $display("FAIL evict_worse: ovf=%b ev=%h kvo=%h, want 1 3259 0158", ovf[1], ev_kv[1], kvo[1]);
    end
  endtask

  task automatic test_replace();
    logic [15:0] want [4];
    want[0] = 16'h1402; want[1] = 16'h195A; want[2] = 16'h1E03; want[3] = 16'h2804;
    fill4();
    n_tests++;
    if (kvo[0] !== 16'h0A01) begin
      n_fail++;
      $display("FAIL repl_before: kvo=%h want 0a01", kvo[0]);
    end
    step(1'b0, 1'b1, 1'b1, 16'h195A);
    n_tests++;
    if (ovf[0] !== 1'b0 || count[0] !== 3'd4) begin
      n_fail++;
      $display("FAIL repl_state: ovf=%b count=%0d, want 0 4", ovf[0], count[0]);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (kvo[0] !== want[i]) begin
        n_fail++;
        $display("FAIL repl_order%0d: kvo=%h want %h", i, kvo[0], want[i]);
      end
      step(1'b0, 1'b0, 1'b1, 16'h0);
    end
  endtask

  task automatic test_underflow();
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b1, 16'h0);
    n_tests++;
    if (unf[0] !== 1'b1 || count[0] !== 3'd0) begin
      n_fail++;
      $display("FAIL unf_empty: unf=%b count=%0d, want 1 0", unf[0], count[0]);
    end
    step(1'b0, 1'b0, 1'b0, 16'h0);
    n_tests++;
    if (unf[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL unf_pulse: unf=%b want 0", unf[0]);
    end
    step(1'b0, 1'b1, 1'b1, 16'h0751);
    n_tests++;
    if ({unf[0], count[0], kvo[0]} !== {1'b1, 3'd1, 16'h0751}) begin
      n_fail++;
      $display("FAIL unf_enqdeq: unf=%b count=%0d kvo=%h, want 1 1 0751", unf[0], count[0], kvo[0]);
    end
  endtask

  task automatic test_reset_override();
    step(1'b0, 1'b1, 1'b0, 16'h0301);
    step(1'b0, 1'b1, 1'b0, 16'h0902);
    n_tests++;
    if (count[0] !== 3'd3) begin
      n_fail++;
      $display("FAIL rst_pre: count=%0d want 3", count[0]);
    end
    step(1'b1, 1'b1, 1'b0, 16'h0203);
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if ({count[c], empty[c], kvo[c]} !== {3'd0, 1'b1, sentinel(c)}) begin
        n_fail++;
        $display("FAIL rst_override dut%0d: count=%0d empty=%b kvo=%h, want 0 1 %h",
                 c, count[c], empty[c], kvo[c], sentinel(c));
      end
    end
  endtask

  task automatic test_max_order();
    logic [15:0] want [3];
    want[0] = 16'h0902; want[1] = 16'h0603; want[2] = 16'h0301;
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0301);
    step(1'b0, 1'b1, 1'b0, 16'h0902);
    step(1'b0, 1'b1, 1'b0, 16'h0603);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (kvo[2] !== want[i]) begin
        n_fail++;
        $display("FAIL max_deq%0d: kvo=%h want %h", i, kvo[2], want[i]);
      end
      step(1'b0, 1'b0, 1'b1, 16'h0);
    end
  endtask

  task automatic test_random();
    logic       r, e, d;
    logic [7:0] k;
    step(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 9) < 6);
      d = ($urandom_range(0, 9) < 5);
      k = 8'($urandom_range(0, 15));
      step(r, e, d, {k, 8'(i)});
      for (int c = 0; c < 3; c++) begin
        n_tests++;
        if ({kvo[c], count[c], full[c], empty[c]} !==
            {exp_kvo(c), 3'(mc[c]), (mc[c] == 4), (mc[c] == 0)}) begin
          n_fail++;
          $display("FAIL rand_state dut%0d cyc%0d: kvo=%h count=%0d full=%b empty=%b, want kvo=%h count=%0d",
                   c, i, kvo[c], count[c], full[c], empty[c], exp_kvo(c), mc[c]);
        end
        n_tests++;
        if ({ovf[c], unf[c]} !== {e_ovf[c], e_unf[c]} || (e_ovf[c] && ev_kv[c] !== e_ev[c])) begin
          n_fail++;
          $display("FAIL rand_pulse dut%0d cyc%0d: ovf=%b unf=%b ev=%h, want ovf=%b unf=%b ev=%h",
                   c, i, ovf[c], unf[c], ev_kv[c], e_ovf[c], e_unf[c], e_ev[c]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; enq = 1'b0; deq = 1'b0; kvi = 16'h0;
    for (int c = 0; c < 3; c++) mc[c] = 0;
    test_reset();
    test_sorted();
    test_ties();
    test_overflow();
    test_replace();
    test_underflow();
    test_reset_override();
    test_max_order();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
